// File: rtl/hwpe_ctrl_job_seq.sv
// hwpe_ctrl_job_seq: turns one start pulse into N_TILES tile commands on a
// valid/ready channel, tracks tile completions and returns a one-cycle done.
// Optional performance counters are built when HWPE_CTRL_JOB_SEQ_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start_i, job registers latched on accepted start
// ISSUE | issuing tile commands, throttled by MAX_OUT outstanding tiles
// WAIT  | all tiles issued, waiting for the remaining completions
// DONE  | one-cycle done_o pulse, then back to IDLE
module hwpe_ctrl_job_seq #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_tiles_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic              cmd_last_o,
  input  logic              cmp_i,
  output logic              tile_evt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
`ifdef HWPE_CTRL_JOB_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0]  n_tiles_q, n_tiles_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  completed_q, completed_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic              err_q, err_d;
  logic              evt_q, evt_d;
  logic              cmd_valid, hs, cmp_acc, start_acc;

  // Next-state, counter and command-channel logic
  always_comb begin
    state_d       = state_q;
    n_tiles_d     = n_tiles_q;
    issued_d      = issued_q;
    completed_d   = completed_q;
    outstanding_d = outstanding_q;
    addr_d        = addr_q;
    stride_d      = stride_q;
    err_d         = err_q;

    cmd_valid = (state_q == ISSUE) && (issued_q < n_tiles_q) && (outstanding_q < OUT_MAX);
    hs        = cmd_valid && cmd_ready_i;
    cmp_acc   = cmp_i && (outstanding_q != '0);
    start_acc = (state_q == IDLE) && start_i;
    evt_d     = cmp_acc;

    if (hs) begin
      issued_d = issued_q + CNT_ONE;
      addr_d   = addr_q + stride_q;
    end
    if (cmp_acc) completed_d = completed_q + CNT_ONE;

    // A handshake and a completion in the same cycle cancel out
    unique case ({hs, cmp_acc})
      2'b10:   outstanding_d = outstanding_q + OUT_ONE;
      2'b01:   outstanding_d = outstanding_q - OUT_ONE;
      default: outstanding_d = outstanding_q;
    endcase

    if (start_acc) err_d = 1'b0;
    if ((start_i && state_q != IDLE) || (cmp_i && !cmp_acc)) err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          n_tiles_d     = n_tiles_i;
          addr_d        = base_addr_i;
          stride_d      = stride_i;
          issued_d      = '0;
          completed_d   = '0;
          outstanding_d = '0;
          state_d       = (n_tiles_i == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: if (hs && issued_q == n_tiles_q - CNT_ONE) state_d = WAIT;
      WAIT:  if (completed_d == n_tiles_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      state_d       = IDLE;
      issued_d      = '0;
      completed_d   = '0;
      outstanding_d = '0;
      err_d         = 1'b0;
      evt_d         = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      n_tiles_q     <= '0;
      issued_q      <= '0;
      completed_q   <= '0;
      outstanding_q <= '0;
      addr_q        <= '0;
      stride_q      <= '0;
      err_q         <= 1'b0;
      evt_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_tiles_q     <= n_tiles_d;
      issued_q      <= issued_d;
      completed_q   <= completed_d;
      outstanding_q <= outstanding_d;
      addr_q        <= addr_d;
      stride_q      <= stride_d;
      err_q         <= err_d;
      evt_q         <= evt_d;
    end
  end

  assign cmd_valid_o = cmd_valid;
  assign cmd_addr_o  = addr_q;
  assign cmd_last_o  = cmd_valid && (issued_q == n_tiles_q - CNT_ONE);
  assign tile_evt_o  = evt_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;

`ifdef HWPE_CTRL_JOB_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_stall_q;

  // Saturating busy-cycle and backpressure-stall counters, restarted per job
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (clear_i || start_acc) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (busy_o && perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (cmd_valid && !cmd_ready_i && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_hwpe_ctrl_job_seq.sv
// Testbench for hwpe_ctrl_job_seq: directed jobs, expected commands and done
// tokens queued by the stimulus, checked by a separate negedge monitor.
module tb_hwpe_ctrl_job_seq;
  localparam int CNT_W   = 16;
  localparam int ADDR_W  = 32;
  localparam int MAX_OUT = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              clear_i = 1'b0;
  logic              start_i = 1'b0;
  logic [CNT_W-1:0]  n_tiles_i = '0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic [ADDR_W-1:0] stride_i = '0;
  logic              cmd_valid_o;
  logic              cmd_ready_i = 1'b0;
  logic [ADDR_W-1:0] cmd_addr_o;
  logic              cmd_last_o;
  logic              cmp_i = 1'b0;
  logic              tile_evt_o, busy_o, done_o, err_o;
`ifdef HWPE_CTRL_JOB_SEQ_PERF_EN
  logic [31:0]       perf_cycles_o, perf_stall_o;
`endif

  hwpe_ctrl_job_seq #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .n_tiles_i(n_tiles_i), .base_addr_i(base_addr_i), .stride_i(stride_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_addr_o(cmd_addr_o),
    .cmd_last_o(cmd_last_o), .cmp_i(cmp_i), .tile_evt_o(tile_evt_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
`ifdef HWPE_CTRL_JOB_SEQ_PERF_EN
    , .perf_cycles_o(perf_cycles_o), .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [31:0] addr; logic last;} cmd_t;
  cmd_t exp_cmd[$];
  int   exp_done[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard for commands/done, reference model for tile_evt_o and err_o
  int   out_m = 0, evt_cnt = 0, hs_cnt = 0;
  logic exp_evt = 1'b0, exp_err = 1'b0, done_prev = 1'b0;
  always @(negedge clk_i) begin
    logic hs, acc, bad;
    cmd_t c;
    int   e;
    if (!rst_ni) begin
      out_m = 0; evt_cnt = 0; hs_cnt = 0;
      exp_evt = 1'b0; exp_err = 1'b0; done_prev = 1'b0;
    end else begin
      chk("tile_evt", tile_evt_o, exp_evt);
      chk("err", err_o, exp_err);
      if (tile_evt_o) evt_cnt++;
      if (out_m >= MAX_OUT) chk("valid_at_limit", cmd_valid_o, 0);
      hs = cmd_valid_o && cmd_ready_i;
      if (hs) begin
        hs_cnt++;
        n_checks++;
        if (exp_cmd.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_cmd: got addr 0x%0h with nothing expected", cmd_addr_o);
        end else begin
          c = exp_cmd.pop_front();
          chk("cmd_addr", cmd_addr_o, c.addr);
          chk("cmd_last", cmd_last_o, c.last);
        end
      end
      if (done_o) begin
        chk("done_single_cycle", done_prev, 0);
        n_checks++;
        if (exp_done.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_done: got done_o=1 with no job expected");
        end else begin
          e = exp_done.pop_front();
          chk("done_tile_evts", evt_cnt, e);
          chk("done_handshakes", hs_cnt, e);
        end
      end
      done_prev = done_o;
      if (clear_i) begin
        out_m = 0; evt_cnt = 0; hs_cnt = 0;
        exp_evt = 1'b0; exp_err = 1'b0;
      end else begin
        acc = cmp_i && (out_m > 0);
        bad = (cmp_i && out_m == 0) || (start_i && busy_o);
        if (start_i && !busy_o) begin
          exp_err = bad; evt_cnt = 0; hs_cnt = 0;
        end else begin
          exp_err = exp_err | bad;
        end
        out_m = out_m + int'(hs) - int'(acc);
        exp_evt = acc;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // Run one job: ready low for cycles 1..rdy_low, each tile completes dly cycles after its handshake
  task automatic run_job(input logic [15:0] n, input logic [31:0] base, input logic [31:0] stride,
                         input int rdy_low, input int dly, output int lat);
    int  hs_t[$];
    int  t, stalls, ni;
    bit  seen;
    ni = int'(n);
    for (int i = 0; i < ni; i++) exp_cmd.push_back('{addr: base + stride * i, last: (i == ni - 1)});
    exp_done.push_back(ni);
    n_tiles_i = n; base_addr_i = base; stride_i = stride; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    t = 1; seen = 0; lat = -1; stalls = 0;
    cmd_ready_i = (t > rdy_low);
    while (!seen && t < 300) begin
      @(negedge clk_i);
      if (done_o) begin seen = 1; lat = t; end
      if (cmd_valid_o && cmd_ready_i) hs_t.push_back(t);
      if (cmd_valid_o && !cmd_ready_i) begin
        stalls++;
        chk("bp_addr_stable", cmd_addr_o, base);
      end
      tick();
      t++;
      cmd_ready_i = (t > rdy_low);
      cmp_i = 1'b0;
      if (hs_t.size() > 0 && hs_t[0] + dly == t) begin
        cmp_i = 1'b1;
        void'(hs_t.pop_front());
      end
    end
    cmp_i = 1'b0;
    chk("job_finished", seen, 1);
    chk("stall_cycles", stalls, rdy_low);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, hs;
    // Reset values
    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);   chk("rst_done", done_o, 0);
    chk("rst_valid", cmd_valid_o, 0); chk("rst_last", cmd_last_o, 0);
    chk("rst_addr", cmd_addr_o, 0); chk("rst_err", err_o, 0);
    chk("rst_evt", tile_evt_o, 0);
    tick(); rst_ni = 1'b1; tick();

    // Basic job
    run_job(3, 32'h1000, 32'h40, 0, 2, lat);
    chk("basic_latency", lat, 6);
    chk("basic_busy_after", busy_o, 0);

    // Minimum single-tile latency, then zero-tile job back to back
    run_job(1, 32'h8000, 32'h0, 0, 1, lat);
    chk("one_tile_latency", lat, 3);
    run_job(0, 32'h9000, 32'h4, 0, 1, lat);
    chk("zero_tile_latency", lat, 1);

    // Backpressure
    run_job(2, 32'h2000, 32'h10, 5, 2, lat);
    chk("bp_latency", lat, 10);
`ifdef HWPE_CTRL_JOB_SEQ_PERF_EN
    chk("perf_stall", perf_stall_o, 5);
    chk("perf_cycles", perf_cycles_o, 10);
`endif

    // Completion in the same cycle as each later handshake keeps one tile outstanding
    run_job(8, 32'hA000, 32'h20, 0, 1, lat);
    chk("simul_latency", lat, 10);

    // Completion with nothing outstanding
    cmp_i = 1'b1; tick(); cmp_i = 1'b0;
    @(negedge clk_i);
    chk("bad_cmp_err", err_o, 1);
    chk("bad_cmp_no_evt", tile_evt_o, 0);
    tick();

    // Outstanding limit
    for (int i = 0; i < 6; i++) exp_cmd.push_back('{addr: 32'h3000 + 32'(4 * i), last: (i == 5)});
    exp_done.push_back(6);
    n_tiles_i = 6; base_addr_i = 32'h3000; stride_i = 32'h4; start_i = 1'b1;
    tick(); start_i = 1'b0; cmd_ready_i = 1'b1; hs = 0;
    repeat (8) begin
      @(negedge clk_i); if (cmd_valid_o && cmd_ready_i) hs++;
      tick();
    end
    chk("limit_handshakes", hs, 4);
    chk("limit_valid_low", cmd_valid_o, 0);
    start_i = 1'b1; tick(); start_i = 1'b0;
    @(negedge clk_i);
    chk("busy_start_err", err_o, 1);
    tick();
    for (int k = 0; k < 6; k++) begin
      cmp_i = 1'b1; hs = 0;
      repeat (4) begin
        @(negedge clk_i); if (cmd_valid_o && cmd_ready_i) hs++;
        tick(); cmp_i = 1'b0;
      end
      chk("limit_refill", hs, (k < 2) ? 1 : 0);
    end
    chk("limit_busy_after", busy_o, 0);

    // clear_i mid-ISSUE at issued=2 of 8, with a dropped start in the same cycle
    exp_cmd.push_back('{addr: 32'h4000, last: 1'b0});
    exp_cmd.push_back('{addr: 32'h4100, last: 1'b0});
    n_tiles_i = 8; base_addr_i = 32'h4000; stride_i = 32'h100; start_i = 1'b1;
    tick(); start_i = 1'b0; cmd_ready_i = 1'b1;
    tick(); start_i = 1'b1;
    tick(); start_i = 1'b1; clear_i = 1'b1; cmd_ready_i = 1'b0;
    tick(); start_i = 1'b0; clear_i = 1'b0;
    @(negedge clk_i);
    chk("clear_busy", busy_o, 0); chk("clear_valid", cmd_valid_o, 0);
    chk("clear_err", err_o, 0);   chk("clear_done", done_o, 0);
    tick();
    @(negedge clk_i);
    chk("clear_start_dropped", busy_o, 0);
    tick();
    run_job(8, 32'h4000, 32'h100, 0, 1, lat);
    chk("after_clear_latency", lat, 10);

    // rst_ni mid-WAIT
    exp_cmd.push_back('{addr: 32'h5000, last: 1'b0});
    exp_cmd.push_back('{addr: 32'h5008, last: 1'b1});
    n_tiles_i = 2; base_addr_i = 32'h5000; stride_i = 32'h8; start_i = 1'b1;
    tick(); start_i = 1'b0; cmd_ready_i = 1'b1;
    tick(); tick();
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("wait_rst_busy", busy_o, 0); chk("wait_rst_valid", cmd_valid_o, 0);
    chk("wait_rst_done", done_o, 0); chk("wait_rst_addr", cmd_addr_o, 0);
    tick(); rst_ni = 1'b1; tick();
    run_job(8, 32'h5000, 32'h8, 0, 2, lat);
    chk("after_rst_latency", lat, 11);

    tick();
    chk("cmd_queue_drained", exp_cmd.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hwpe_ctrl_job_seq.md
Name: hwpe_ctrl_job_seq

Overview:
- Downstream consumer of the control slave's start pulse and job registers.
- On each start it sequences one offloaded job as N_TILES tile commands to the streamer/engine over a valid/ready channel, tracks per-tile completions, and returns a single-cycle done pulse.
- That done pulse is what the slave qualifies into its true_done and end-of-job event.
- Sits between the control slave (register file/flags) and the datapath streamer.

Parameters:
- CNT_W, 16: width of tile count and tile counters.
- ADDR_W, 32: command address width.
- MAX_OUT, 4: maximum tiles issued but not yet completed (1..2^CNT_W-1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft clear (driven from slave clear_o)
- start_i  in  1  one-cycle job start pulse
- n_tiles_i  in  CNT_W  tiles in the job, sampled at accepted start
- base_addr_i  in  ADDR_W  first tile address, sampled at accepted start
- stride_i  in  ADDR_W  address increment per tile, sampled at accepted start
- cmd_valid_o  out  1  tile command valid
- cmd_ready_i  in  1  tile command ready
- cmd_addr_o  out  ADDR_W  tile address
- cmd_last_o  out  1  command is the final tile of the job
- cmp_i  in  1  one-cycle pulse, one tile completed
- tile_evt_o  out  1  registered pulse, one cycle after each accepted cmp_i
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle end-of-job pulse
- err_o  out  1  sticky protocol error flag

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Counters issued_q, completed_q and outstanding_q are 0.
  - Latched count, address and stride are 0.
- States:
  - IDLE:
    - start_i latches n_tiles_i, base_addr_i and stride_i.
    - Goes to ISSUE, or to DONE if n_tiles_i==0.
    - start_i is ignored in every other state; such a start sets err_o.
  - ISSUE:
    - cmd_valid_o = (issued_q < n_tiles_q) && (outstanding_q < MAX_OUT).
    - Handshake when cmd_valid_o && cmd_ready_i.
    - On handshake: issued_q+1, address accumulator += stride (modulo 2^ADDR_W).
    - Goes to WAIT on the handshake of the tile with issued_q == n_tiles_q-1.
  - WAIT:
    - cmd_valid_o = 0.
    - Goes to DONE in the cycle after completed_q reaches n_tiles_q.
    - A cmp_i that arrives in the same cycle as the last handshake is counted normally.
  - DONE:
    - done_o=1 for exactly this one cycle, then IDLE.
    - The first cycle at which a new start can be accepted is the IDLE cycle after DONE.
- Command channel:
  - cmd_addr_o = base + issued_q*stride, from an accumulator (no multiplier).
  - cmd_last_o = cmd_valid_o && issued_q == n_tiles_q-1.
  - While cmd_valid_o=1 and cmd_ready_i=0, cmd_addr_o and cmd_last_o hold stable.
  - cmd_valid_o never drops without a handshake, except on clear_i or reset.
  - cmd_valid_o is combinational from state and counters; it does not depend on cmd_ready_i.
- Outstanding tracking:
  - Handshake only: outstanding_q+1.
  - cmp_i only: outstanding_q-1, completed_q+1.
  - Handshake and cmp_i in the same cycle: outstanding_q unchanged, completed_q+1.
- Errors:
  - cmp_i while outstanding_q==0 is ignored (no counter change, no tile_evt_o) and sets err_o.
  - err_o clears only on reset, on clear_i, or on an accepted start.
- Timing:
  - Minimum job latency start_i to done_o is 3 cycles for one tile, with ready=1 and a cmp_i in the cycle after the handshake.
  - A zero-tile job gives done_o one cycle after start_i.
- clear_i:
  - Highest priority after reset.
  - Next cycle: IDLE, all counters 0, cmd_valid_o=0, err_o=0, no done_o or tile_evt_o.
  - A start_i in the same cycle as clear_i is dropped.
- Counter widths:
  - issued_q and completed_q are CNT_W bits; outstanding_q is $clog2(MAX_OUT+1) bits.
  - n_tiles up to 2^CNT_W-1 is supported with no wrap.

Optional Feature:
- Macro: HWPE_CTRL_JOB_SEQ_PERF_EN.
- When defined:
  - Adds outputs perf_cycles_o (32 bits) and perf_stall_o (32 bits).
  - perf_cycles_o counts cycles with busy_o=1 for the current or last job; it clears on accepted start and saturates at 2^32-1.
  - perf_stall_o counts ISSUE-state cycles where cmd_valid_o=1 and cmd_ready_i=0.
  - Both counters hold their value after DONE and reset to 0 on rst_ni or clear_i.
- When not defined: neither port exists, and there is no counter logic.

Test Plan:
- Basic job:
  - Stimulus: start with n_tiles=3, base=0x1000, stride=0x40, ready=1, cmp_i 2 cycles after each handshake.
  - Response: addresses 0x1000, 0x1040, 0x1080; cmd_last_o only on 0x1080; 3 tile_evt_o pulses; a single done_o pulse; busy_o low after.
- Backpressure:
  - Stimulus: n_tiles=2, cmd_ready_i low for 5 cycles.
  - Response: cmd_valid_o held high with cmd_addr_o stable at base for 5 cycles; perf_stall_o=5 when the macro is defined.
- Outstanding limit:
  - Stimulus: MAX_OUT=4, n_tiles=6, cmp_i withheld.
  - Response: exactly 4 handshakes, then cmd_valid_o=0.
  - Follow-up: one cmp_i is followed by exactly one more issue, and so on until done.
- Zero-tile job:
  - Stimulus: start with n_tiles=0.
  - Response: no cmd_valid_o; done_o high the next cycle.
- Simultaneous events:
  - Stimulus: cmp_i in the same cycle as a handshake; in a separate job, cmp_i with none outstanding.
  - Response: outstanding unchanged for the first; err_o=1 and no tile_evt_o for the second.
- Mid-job disturbance:
  - Stimulus: clear_i mid-ISSUE at issued=2 of 8; in a separate run, rst_ni low mid-WAIT.
  - Response: next cycle IDLE, cmd_valid_o=0, done_o never pulses; a new start runs 8 tiles from base.
